// File: rtl/gearbox_fsm_param.sv
// rtl/gearbox_fsm_param.sv - debounced gear selector FSM with lockout and timed brake downshifts
// Optional reverse gear is enabled by defining REVERSE_GEAR_EN.
module gearbox_fsm_param #(
    parameter int NUM_GEARS         = 5,
    parameter int DEBOUNCE_CYCLES   = 250,
    parameter int SHIFT_LOCK_CYCLES = 125,
    parameter int BRAKE_STEP_CYCLES = 2500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       shift_up,
    input  logic       shift_down,
    input  logic       brake,
    output logic [3:0] gear,
    output logic [6:0] seg,
    output logic       shift_busy,
    output logic       neutral
);

    generate
        if (NUM_GEARS < 1 || NUM_GEARS > 9) begin : g_bad_num_gears
            $error("NUM_GEARS must be in 1..9");
        end
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
            $error("DEBOUNCE_CYCLES must be >= 2");
        end
        if (SHIFT_LOCK_CYCLES < 1) begin : g_bad_lock
            $error("SHIFT_LOCK_CYCLES must be >= 1");
        end
        if (BRAKE_STEP_CYCLES < 2) begin : g_bad_brake
            $error("BRAKE_STEP_CYCLES must be >= 2");
        end
    endgenerate

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int LK_W = (SHIFT_LOCK_CYCLES > 1) ? $clog2(SHIFT_LOCK_CYCLES) : 1;
    localparam int BK_W = $clog2(BRAKE_STEP_CYCLES);

    localparam logic [3:0]      TOP_GEAR  = 4'(NUM_GEARS);
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LK_W-1:0] LOCK_LOAD = LK_W'(SHIFT_LOCK_CYCLES - 1);
    localparam logic [BK_W-1:0] STEP_LAST = BK_W'(BRAKE_STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        READY   = 2'd0,
        LOCKOUT = 2'd1,
        BRAKING = 2'd2
    } state_t;

    // Input conditioning: bit 0 = shift_up, bit 1 = shift_down, bit 2 = brake
    logic [2:0]      raw;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      lvl;
    logic [1:0]      lvl_q;
    logic [DB_W-1:0] db_cnt [3];
    logic            up_p;
    logic            dn_p;
    logic            brake_db;

    assign raw      = {brake, shift_down, shift_up};
    assign brake_db = lvl[2];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            lvl   <= '0;
            lvl_q <= '0;
            up_p  <= 1'b0;
            dn_p  <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            lvl_q <= lvl[1:0];
            up_p  <= lvl[0] & ~lvl_q[0];
            dn_p  <= lvl[1] & ~lvl_q[1];
            // A level flips only after an unbroken run of disagreeing samples
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != lvl[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        lvl[i]    <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      gear_nxt;
    logic [LK_W-1:0] lock_cnt;
    logic [LK_W-1:0] lock_nxt;
    logic [BK_W-1:0] step_cnt;
    logic [BK_W-1:0] step_nxt;
    logic            brakeable;

    assign brakeable = (gear >= 4'd2) && (gear <= TOP_GEAR);

    always_comb begin
        state_nxt = state;
        gear_nxt  = gear;
        lock_nxt  = lock_cnt;
        step_nxt  = step_cnt;
        case (state)
            READY: begin
                if (brake_db && brakeable) begin
                    state_nxt = BRAKING;
                    step_nxt  = '0;
                end else if (up_p && dn_p) begin
                    state_nxt = READY;
                end else if (up_p && gear < TOP_GEAR) begin
                    gear_nxt  = gear + 4'd1;
                    state_nxt = LOCKOUT;
                    lock_nxt  = LOCK_LOAD;
                end else if (dn_p && gear >= 4'd1 && gear <= TOP_GEAR) begin
                    gear_nxt  = gear - 4'd1;
                    state_nxt = LOCKOUT;
                    lock_nxt  = LOCK_LOAD;
`ifdef REVERSE_GEAR_EN
                end else if (dn_p && gear == 4'd0 && brake_db) begin
                    gear_nxt  = 4'hF;
                    state_nxt = LOCKOUT;
                    lock_nxt  = LOCK_LOAD;
                end else if (up_p && gear == 4'hF) begin
                    gear_nxt  = 4'd0;
                    state_nxt = LOCKOUT;
                    lock_nxt  = LOCK_LOAD;
`endif
                end
            end
            LOCKOUT: begin
                if (lock_cnt == '0) begin
                    state_nxt = READY;
                end else begin
                    lock_nxt = lock_cnt - LK_W'(1);
                end
            end
            BRAKING: begin
                if (!brake_db) begin
                    state_nxt = READY;
                    step_nxt  = '0;
                end else if (step_cnt == STEP_LAST) begin
                    // At gear 1 the counter parks at its terminal value
                    if (gear >= 4'd2) begin
                        gear_nxt = gear - 4'd1;
                        step_nxt = '0;
                    end
                end else begin
                    step_nxt = step_cnt + BK_W'(1);
                end
            end
            default: begin
                state_nxt = READY;
            end
        endcase
    end

    function automatic logic [6:0] seg_of(input logic [3:0] g);
        case (g)
            4'd0:    seg_of = 7'h54;
            4'd1:    seg_of = 7'h06;
            4'd2:    seg_of = 7'h5B;
            4'd3:    seg_of = 7'h4F;
            4'd4:    seg_of = 7'h66;
            4'd5:    seg_of = 7'h6D;
            4'd6:    seg_of = 7'h7D;
            4'd7:    seg_of = 7'h07;
            4'd8:    seg_of = 7'h7F;
            4'd9:    seg_of = 7'h6F;
`ifdef REVERSE_GEAR_EN
            4'hF:    seg_of = 7'h50;
`endif
            default: seg_of = 7'h40;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= READY;
            gear     <= 4'd0;
            lock_cnt <= '0;
            step_cnt <= '0;
            seg      <= 7'h54;
        end else begin
            state    <= state_nxt;
            gear     <= gear_nxt;
            lock_cnt <= lock_nxt;
            step_cnt <= step_nxt;
            seg      <= seg_of(gear);
        end
    end

    assign shift_busy = (state != READY);
    assign neutral    = (gear == 4'd0);

endmodule

// File: tb/tb_gearbox_fsm_param.sv
// tb/tb_gearbox_fsm_param.sv - self-checking bench for gearbox_fsm_param
module tb_gearbox_fsm_param;

    localparam int NG = 5;
    localparam int D  = 4;
    localparam int S  = 3;
    localparam int B  = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       shift_up = 1'b0;
    logic       shift_down = 1'b0;
    logic       brake = 1'b0;
    logic [3:0] gear;
    logic [6:0] seg;
    logic       shift_busy;
    logic       neutral;

    gearbox_fsm_param #(
        .NUM_GEARS(NG),
        .DEBOUNCE_CYCLES(D),
        .SHIFT_LOCK_CYCLES(S),
        .BRAKE_STEP_CYCLES(B)
    ) dut (
        .clk(clk),
        .reset(reset),
        .shift_up(shift_up),
        .shift_down(shift_down),
        .brake(brake),
        .gear(gear),
        .seg(seg),
        .shift_busy(shift_busy),
        .neutral(neutral)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    function automatic logic [7:0] seg_ref(input int g);
        case (g)
            0: return 8'h54;
            1: return 8'h06;
            2: return 8'h5B;
            3: return 8'h4F;
            4: return 8'h66;
            5: return 8'h6D;
            6: return 8'h7D;
            7: return 8'h07;
            8: return 8'h7F;
            9: return 8'h6F;
`ifdef REVERSE_GEAR_EN
            15: return 8'h50;
`endif
            default: return 8'h40;
        endcase
    endfunction

    // Reference model: absolute-time histories of raw samples and debounced levels
    bit raw_h [3][0:4095];
    bit lv_h  [3][0:4095];
    int last_flip [3];
    int n = 8;
    int m_mode = 0;   // 0 ready, 1 lockout, 2 braking
    int m_gear = 0;
    int m_seg  = 'h54;
    int lock_e = 0;
    int brk_e  = 0;

    task automatic model_step(input bit rst, input bit u, input bit d, input bit b);
        bit up, dn, br, cur, flip;
        n++;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                raw_h[i][n] = 1'b0;
                raw_h[i][n-1] = 1'b0;
                lv_h[i][n] = 1'b0;
                lv_h[i][n-1] = 1'b0;
                last_flip[i] = n;
            end
            m_mode = 0;
            m_gear = 0;
            m_seg  = 'h54;
            return;
        end
        raw_h[0][n] = u;
        raw_h[1][n] = d;
        raw_h[2][n] = b;
        for (int i = 0; i < 3; i++) begin
            cur  = lv_h[i][n-1];
            flip = (n - last_flip[i]) >= D;
            for (int k = 0; k < D; k++)
                if (raw_h[i][n-k-2] == cur) flip = 1'b0;
            lv_h[i][n] = flip ? !cur : cur;
            if (flip) last_flip[i] = n;
        end
        up = lv_h[0][n-2] && !lv_h[0][n-3];
        dn = lv_h[1][n-2] && !lv_h[1][n-3];
        br = lv_h[2][n-1];
        m_seg = seg_ref(m_gear);
        case (m_mode)
            0: begin
                if (br && m_gear >= 2 && m_gear <= NG) begin
                    m_mode = 2; brk_e = n;
                end else if (up && dn) begin
                    m_mode = 0;
                end else if (up && m_gear < NG) begin
                    m_gear++; m_mode = 1; lock_e = n;
                end else if (dn && m_gear >= 1 && m_gear <= NG) begin
                    m_gear--; m_mode = 1; lock_e = n;
`ifdef REVERSE_GEAR_EN
                end else if (dn && m_gear == 0 && br) begin
                    m_gear = 15; m_mode = 1; lock_e = n;
                end else if (up && m_gear == 15) begin
                    m_gear = 0; m_mode = 1; lock_e = n;
`endif
                end
            end
            1: if (n - lock_e >= S) m_mode = 0;
            default: begin
                if (!br) m_mode = 0;
                else if ((n - brk_e) % B == 0 && m_gear >= 2) m_gear--;
            end
        endcase
    endtask

    typedef struct {
        bit         up;
        bit         dn;
        bit         br;
        logic [7:0] exp_gear;
        logic [7:0] exp_seg;
    } vec_t;

    vec_t vecs [17];

    initial begin
        int hu, hd, hb;
        bit ru, rd, rb, rr;

        vecs[0]  = '{1, 0, 0, 8'd4, 8'h66};
        vecs[1]  = '{1, 0, 0, 8'd5, 8'h6D};
        vecs[2]  = '{1, 0, 0, 8'd5, 8'h6D};
        vecs[3]  = '{1, 0, 0, 8'd5, 8'h6D};
        vecs[4]  = '{0, 1, 0, 8'd4, 8'h66};
        vecs[5]  = '{0, 1, 0, 8'd3, 8'h4F};
        vecs[6]  = '{0, 1, 0, 8'd2, 8'h5B};
        vecs[7]  = '{0, 1, 0, 8'd1, 8'h06};
        vecs[8]  = '{0, 1, 0, 8'd0, 8'h54};
        vecs[9]  = '{0, 1, 0, 8'd0, 8'h54};
`ifdef REVERSE_GEAR_EN
        vecs[10] = '{0, 1, 1, 8'hF, 8'h50};
        vecs[11] = '{1, 0, 0, 8'd0, 8'h54};
`else
        vecs[10] = '{0, 1, 1, 8'd0, 8'h54};
        vecs[11] = '{1, 0, 0, 8'd1, 8'h06};
`endif
        vecs[12] = '{0, 1, 0, 8'd0, 8'h54};
        vecs[13] = '{1, 0, 0, 8'd1, 8'h06};
        vecs[14] = '{1, 0, 0, 8'd2, 8'h5B};
        vecs[15] = '{1, 0, 0, 8'd3, 8'h4F};
        vecs[16] = '{1, 0, 0, 8'd4, 8'h66};

        // Reset for two cycles
        ticks(2);
        reset = 1'b0;
        chk("reset_gear", gear, 8'd0);
        chk("reset_seg", seg, 8'h54);
        chk("reset_neutral", neutral, 8'd1);
        chk("reset_busy", shift_busy, 8'd0);

        // First press: latency, seg lag and lockout width
        shift_up = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("lat_gear", gear, (k >= 7) ? 8'd1 : 8'd0);
            chk("lat_seg", seg, (k >= 8) ? 8'h06 : 8'h54);
            chk("lat_busy", shift_busy, (k >= 7 && k <= 9) ? 8'd1 : 8'd0);
            chk("lat_neutral", neutral, (k >= 7) ? 8'd0 : 8'd1);
            if (k == 9) shift_up = 1'b0;
        end
        ticks(12);

        // Short glitch is rejected
        shift_up = 1'b1;
        ticks(3);
        shift_up = 1'b0;
        ticks(12);
        chk("glitch_gear", gear, 8'd1);

        // Down pulse landing inside the up lockout is dropped
        shift_up = 1'b1;
        tick();
        shift_down = 1'b1;
        ticks(5);
        shift_up = 1'b0;
        tick();
        shift_down = 1'b0;
        ticks(14);
        chk("lockout_discard_gear", gear, 8'd2);
        shift_up = 1'b1;
        ticks(6);
        shift_up = 1'b0;
        ticks(12);
        chk("after_lockout_gear", gear, 8'd3);

        // Table of single presses
        for (int v = 0; v < 17; v++) begin
            shift_up   = vecs[v].up;
            shift_down = vecs[v].dn;
            brake      = vecs[v].br;
            ticks(6);
            shift_up   = 1'b0;
            shift_down = 1'b0;
            brake      = 1'b0;
            ticks(12);
            chk($sformatf("vec%0d_gear", v), gear, vecs[v].exp_gear);
            chk($sformatf("vec%0d_seg", v), seg, vecs[v].exp_seg);
            chk($sformatf("vec%0d_busy", v), shift_busy, 8'd0);
        end

        // Brake from gear 4: steps at 8-cycle intervals after entry, stops at 1
        brake = 1'b1;
        for (int k = 0; k < 52; k++) begin
            tick();
            if (k == 39) brake = 1'b0;
            chk("brake_gear", gear, (k < 14) ? 8'd4 : (k < 22) ? 8'd3 : (k < 30) ? 8'd2 : 8'd1);
            chk("brake_busy", shift_busy, (k >= 6 && k < 46) ? 8'd1 : 8'd0);
        end

        // Randomised run against the reference model, with occasional resets
        reset = 1'b1;
        tick();
        model_step(1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        hu = 0; hd = 0; hb = 0;
        ru = 0; rd = 0; rb = 0;
        for (int c = 0; c < 2500; c++) begin
            if (hu == 0) begin ru = 1'($urandom_range(0, 1)); hu = $urandom_range(1, 14); end
            if (hd == 0) begin rd = 1'($urandom_range(0, 1)); hd = $urandom_range(1, 14); end
            if (hb == 0) begin rb = 1'($urandom_range(0, 1)); hb = $urandom_range(1, 40); end
            hu--; hd--; hb--;
            rr = ($urandom_range(0, 399) == 0);
            shift_up   = ru;
            shift_down = rd;
            brake      = rb;
            reset      = rr;
            tick();
            model_step(rr, ru, rd, rb);
            chk("rnd_gear", gear, 8'(m_gear));
            chk("rnd_seg", seg, 8'(m_seg));
            chk("rnd_busy", shift_busy, (m_mode != 0) ? 8'd1 : 8'd0);
            chk("rnd_neutral", neutral, (m_gear == 0) ? 8'd1 : 8'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gearbox_fsm_param.md
Name: gearbox_fsm_param

Overview:
- Parametrised next-generation gear selector FSM for the TinyTapeout top level.
- Takes raw button inputs `shift_up`, `shift_down` and `brake`. Debounces them, edge-detects the shift buttons, enforces a post-shift lockout and performs timed automatic downshifts while braking.
- Drives a binary gear code and a registered 7-segment pattern.
- Drop-in successor to the fixed-gear FSM instanced under the top wrapper; the wrapper maps `seg` to `uo_out[6:0]`.

Parameters:
- NUM_GEARS, 5, number of forward gears; legal range 1..9, anything else is an elaboration error.
- DEBOUNCE_CYCLES, 250, consecutive stable samples needed to accept an input level (10 ms at 25 kHz); must be ≥2.
- SHIFT_LOCK_CYCLES, 125, lockout length after a manual shift; must be ≥1.
- BRAKE_STEP_CYCLES, 2500, interval between automatic downshifts while brake is held; must be ≥2.

Ports:
- clk  input  1  system clock, 25 kHz nominal.
- reset  input  1  synchronous, active-high reset.
- shift_up  input  1  raw, asynchronous button input.
- shift_down  input  1  raw, asynchronous button input.
- brake  input  1  raw, asynchronous level input.
- gear  output  4  current gear, registered: 0 = neutral, 1..NUM_GEARS = forward gear, 4'hF = reverse (only with the option).
- seg  output  7  registered 7-segment pattern, active-high; bit0 = a … bit6 = g.
- shift_busy  output  1  high while in LOCKOUT or BRAKING.
- neutral  output  1  high when gear == 0.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous, active-high.
- Reset values, applied on the first edge with reset high, including mid-operation:
  - gear = 0, seg = 7'h54 ("n"), shift_busy = 0, neutral = 1.
  - state = READY; all counters, synchronisers and debounced levels = 0.
- Input conditioning, per input:
  - 2-flop synchroniser, then a debounce counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive synchronised samples differing from it; any agreeing sample clears the counter.
  - A rising edge of debounced `shift_up` or `shift_down` gives a one-cycle pulse (`up_p` / `dn_p`).
- Latency: `gear` updates exactly DEBOUNCE_CYCLES+3 clocks after the first edge that samples a raw shift press high.
- `seg` follows `gear` with one further cycle.
- `neutral` is combinational from the gear register.
- State READY:
  - Priority 1: debounced brake = 1 and gear ≥ 2 → BRAKING, step counter = 0, gear unchanged.
  - Priority 2: `up_p` and `dn_p` in the same cycle → both ignored.
  - Priority 3: `up_p` and gear < NUM_GEARS → gear + 1, then LOCKOUT.
  - Priority 4: `dn_p` and 1 ≤ gear → gear − 1 (1 → 0 = neutral), then LOCKOUT.
  - A shift request at a limit (up at NUM_GEARS, down at 0) is ignored, stays READY, and produces no lockout.
  - Brake with gear 0 or 1 keeps the FSM in READY; manual shifts still work.
- State LOCKOUT:
  - Lock counter loads SHIFT_LOCK_CYCLES−1 on entry and decrements each cycle.
  - When the counter reads 0 → READY.
  - Pulses arriving during LOCKOUT are discarded, not queued.
  - Brake is not acted on until READY.
- State BRAKING:
  - Step counter counts 0..BRAKE_STEP_CYCLES−1.
  - On reaching BRAKE_STEP_CYCLES−1 and gear ≥ 2 → gear − 1, counter = 0. The first auto-downshift therefore lands BRAKE_STEP_CYCLES cycles after entry.
  - Auto-downshift stops at gear 1; it never reaches neutral.
  - Manual pulses are discarded in BRAKING.
  - Debounced brake = 0 → READY on the next edge, counter cleared.
- `seg` encoding:
  - Digits: 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F.
  - Neutral = 54, reverse = 50 ("r"), any other code = 40 ("-").
- Counter widths are sized with $clog2 of the respective parameter; no counter wraps past its terminal value.

Optional Feature:
- Macro: REVERSE_GEAR_EN.
- When defined:
  - In READY, `dn_p` at gear 0 with debounced brake = 1 → gear = 4'hF, then LOCKOUT.
  - `up_p` at reverse → gear 0, then LOCKOUT.
  - `dn_p` at reverse is ignored.
  - Brake in reverse does not enter BRAKING.
  - `seg` shows 7'h50 in reverse.
- When not defined: gear never leaves 0..NUM_GEARS; `dn_p` at neutral is ignored regardless of brake; no reverse logic is synthesised.

Test Plan (NUM_GEARS=5, DEBOUNCE_CYCLES=4, SHIFT_LOCK_CYCLES=3, BRAKE_STEP_CYCLES=8):
- Reset held 2 cycles, then released → gear = 0, seg = 7'h54, neutral = 1, shift_busy = 0.
- Clean `shift_up` press held 10 cycles → gear = 1 exactly 7 cycles after the first sampled high; seg = 06 one cycle later; shift_busy high for 3 cycles.
- `shift_up` glitch of 3 cycles → no gear change. Second clean press during lockout → ignored. Press after lockout ends → gear steps by 1.
- Six separate up presses → gear saturates at 5, seg = 6D. Down press at 0 after a full downshift sequence → gear stays 0.
- Gear 4, brake held 40 cycles → gear steps 4→3→2→1 at 8-cycle intervals after BRAKING entry and holds at 1. Release brake → READY, shift_busy = 0.
- With REVERSE_GEAR_EN: gear 0 + brake + down → gear = F, seg = 50. Then up → gear 0. Without the macro, the same stimulus leaves gear = 0.
